// File: rtl/hc4_ram_arbiter_if.sv
// Request/grant/read-data bundle for one HC4 RAM requester port.
// master = requester side, slave = arbiter side.
interface hc4_ram_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 4
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/hc4_ram_arbiter.sv
// HC4 data RAM with one access slot per clock shared by CPU and host ports,
// CPU-priority arbitration with a host starvation guard, and a zero-fill sequencer.
module hc4_ram_arbiter #(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 4,
    parameter int MAX_CPU_STREAK = 4
) (
    input  logic             clk,
    input  logic             rst,
    hc4_ram_arbiter_if.slave cpu,
    hc4_ram_arbiter_if.slave host,
    input  logic             clr_start,
    output logic             clr_busy,
    output logic             clr_done
);
    localparam int         DEPTH      = 2 ** ADDR_W;
    localparam logic [3:0] STREAK_MAX = 4'(MAX_CPU_STREAK);

    typedef enum logic {
        ARB,
        CLEAR
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] clr_ptr;
    logic [3:0]        streak;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              cpu_gnt;
    logic              host_gnt;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    logic              cpu_rvalid;
    logic              host_rvalid;
    logic [DATA_W-1:0] cpu_rdata;
    logic [DATA_W-1:0] host_rdata;
    logic              clr_done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cpu_gnt    = 1'b0;
        host_gnt   = 1'b0;
        clr_busy   = 1'b0;
        case (state)
            ARB: begin
                if (clr_start) begin
                    state_next = CLEAR;
                end else if (cpu.req && (!host.req || streak < STREAK_MAX)) begin
                    cpu_gnt = 1'b1;
                end else if (host.req) begin
                    host_gnt = 1'b1;
                end
            end
            CLEAR: begin
                clr_busy = 1'b1;
                if (clr_ptr == '1) begin
                    state_next = ARB;
                end
            end
            default: state_next = ARB;
        endcase
        // Reset wins over any request, so no access can slip through a reset cycle.
        if (rst) begin
            cpu_gnt  = 1'b0;
            host_gnt = 1'b0;
        end
    end

    // Single RAM port: the clear sequencer, the host or the CPU drives it.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = cpu.addr;
        mem_wdata = cpu.wdata;
        if (state == CLEAR) begin
            mem_we    = !rst;
            mem_addr  = clr_ptr;
            mem_wdata = '0;
        end else if (host_gnt) begin
            mem_we    = host.we;
            mem_addr  = host.addr;
            mem_wdata = host.wdata;
        end else begin
            mem_we = cpu_gnt && cpu.we;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clr_ptr     <= '0;
            streak      <= '0;
            cpu_rvalid  <= 1'b0;
            host_rvalid <= 1'b0;
            cpu_rdata   <= '0;
            host_rdata  <= '0;
            clr_done_q  <= 1'b0;
        end else begin
            clr_done_q  <= (state == CLEAR) && (clr_ptr == '1);
            cpu_rvalid  <= cpu_gnt && !cpu.we;
            host_rvalid <= host_gnt && !host.we;
            if (cpu_gnt && !cpu.we) begin
                cpu_rdata <= mem[mem_addr];
            end
            if (host_gnt && !host.we) begin
                host_rdata <= mem[mem_addr];
            end
            if (state == CLEAR) begin
                clr_ptr <= clr_ptr + 1'b1;
            end else begin
                clr_ptr <= '0;
            end
            // Streak only moves in ARB; it stays frozen across a clear.
            if (state == ARB) begin
                if (!host.req || host_gnt) begin
                    streak <= '0;
                end else if (cpu_gnt && streak != STREAK_MAX) begin
                    streak <= streak + 4'd1;
                end
            end
        end
    end

    assign cpu.gnt     = cpu_gnt;
    assign cpu.rvalid  = cpu_rvalid;
    assign cpu.rdata   = cpu_rdata;
    assign host.gnt    = host_gnt;
    assign host.rvalid = host_rvalid;
    assign host.rdata  = host_rdata;
    assign clr_done    = clr_done_q;
endmodule

// File: tb/tb_hc4_ram_arbiter.sv
// Directed testbench for hc4_ram_arbiter: reset, access paths, streak guard,
// zero-fill sequencing and reset during a clear.
module tb_hc4_ram_arbiter;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 4;
    localparam int MAXS   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr_start = 1'b0;
    logic clr_busy;
    logic clr_done;

    int pass_cnt  = 0;
    int total_cnt = 0;

    hc4_ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) cpu_bus ();
    hc4_ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) host_bus ();

    hc4_ram_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .MAX_CPU_STREAK(MAXS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cpu(cpu_bus),
        .host(host_bus),
        .clr_start(clr_start),
        .clr_busy(clr_busy),
        .clr_done(clr_done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Inputs change on the falling edge; the grant is sampled 1 unit later.
    task automatic cpu_access(input logic we, input logic [7:0] a, input logic [3:0] d,
                              output int waited, output logic granted);
        cpu_bus.req = 1'b1; cpu_bus.we = we; cpu_bus.addr = a; cpu_bus.wdata = d;
        waited = 0;
        #1;
        while (!cpu_bus.gnt && waited < 400) begin
            @(negedge clk); #1; waited++;
        end
        granted = cpu_bus.gnt;
        @(negedge clk);
        cpu_bus.req = 1'b0;
    endtask

    task automatic host_access(input logic we, input logic [7:0] a, input logic [3:0] d,
                               output int waited, output logic granted);
        host_bus.req = 1'b1; host_bus.we = we; host_bus.addr = a; host_bus.wdata = d;
        waited = 0;
        #1;
        while (!host_bus.gnt && waited < 400) begin
            @(negedge clk); #1; waited++;
        end
        granted = host_bus.gnt;
        @(negedge clk);
        host_bus.req = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        cpu_bus.req = 1'b1; host_bus.req = 1'b1;
        #1;
        total_cnt++; if (cpu_bus.gnt !== 1'b0) $display("FAIL reset_cpu_gnt: got %b expected 0", cpu_bus.gnt); else pass_cnt++;
        total_cnt++; if (host_bus.gnt !== 1'b0) $display("FAIL reset_host_gnt: got %b expected 0", host_bus.gnt); else pass_cnt++;
        total_cnt++; if (cpu_bus.rvalid !== 1'b0) $display("FAIL reset_cpu_rvalid: got %b expected 0", cpu_bus.rvalid); else pass_cnt++;
        total_cnt++; if (host_bus.rvalid !== 1'b0) $display("FAIL reset_host_rvalid: got %b expected 0", host_bus.rvalid); else pass_cnt++;
        total_cnt++; if (cpu_bus.rdata !== 4'h0) $display("FAIL reset_cpu_rdata: got %h expected 0", cpu_bus.rdata); else pass_cnt++;
        total_cnt++; if (host_bus.rdata !== 4'h0) $display("FAIL reset_host_rdata: got %h expected 0", host_bus.rdata); else pass_cnt++;
        total_cnt++; if (clr_busy !== 1'b0) $display("FAIL reset_clr_busy: got %b expected 0", clr_busy); else pass_cnt++;
        total_cnt++; if (clr_done !== 1'b0) $display("FAIL reset_clr_done: got %b expected 0", clr_done); else pass_cnt++;
        @(negedge clk);
        cpu_bus.req = 1'b0; host_bus.req = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_write_read();
        int w; logic g;
        cpu_access(1'b1, 8'h3A, 4'h7, w, g);
        total_cnt++; if (!(g === 1'b1 && w == 0)) $display("FAIL wr_cpu_gnt_first: granted %b after %0d waits, expected 1 after 0", g, w); else pass_cnt++;
        total_cnt++; if (cpu_bus.rvalid !== 1'b0) $display("FAIL wr_no_rvalid: got %b expected 0", cpu_bus.rvalid); else pass_cnt++;
        host_access(1'b0, 8'h3A, 4'h0, w, g);
        total_cnt++; if (!(g === 1'b1 && w == 0)) $display("FAIL rd_host_gnt_next: granted %b after %0d waits, expected 1 after 0", g, w); else pass_cnt++;
        total_cnt++; if (host_bus.rvalid !== 1'b1) $display("FAIL rd_host_rvalid: got %b expected 1", host_bus.rvalid); else pass_cnt++;
        total_cnt++; if (host_bus.rdata !== 4'h7) $display("FAIL rd_host_rdata: got %h expected 7", host_bus.rdata); else pass_cnt++;
        total_cnt++; if (cpu_bus.rvalid !== 1'b0) $display("FAIL rd_cpu_rvalid_quiet: got %b expected 0", cpu_bus.rvalid); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (host_bus.rvalid !== 1'b0) $display("FAIL rd_rvalid_pulse: got %b expected 0", host_bus.rvalid); else pass_cnt++;
        total_cnt++; if (host_bus.rdata !== 4'h7) $display("FAIL rd_rdata_hold: got %h expected 7", host_bus.rdata); else pass_cnt++;
    endtask

    task automatic test_priority_streak();
        logic exp_c;
        logic prev_c = 1'b0;
        cpu_bus.req = 1'b1; cpu_bus.we = 1'b0; cpu_bus.addr = 8'h3A;
        host_bus.req = 1'b1; host_bus.we = 1'b0; host_bus.addr = 8'h3A;
        for (int i = 0; i < 15; i++) begin
            exp_c = (i % 5) != 4;
            #1;
            total_cnt++; if (cpu_bus.gnt !== exp_c) $display("FAIL streak_cpu_gnt[%0d]: got %b expected %b", i, cpu_bus.gnt, exp_c); else pass_cnt++;
            total_cnt++; if (host_bus.gnt !== !exp_c) $display("FAIL streak_host_gnt[%0d]: got %b expected %b", i, host_bus.gnt, !exp_c); else pass_cnt++;
            if (i > 0) begin
                total_cnt++; if (cpu_bus.rvalid !== prev_c) $display("FAIL streak_cpu_rvalid[%0d]: got %b expected %b", i, cpu_bus.rvalid, prev_c); else pass_cnt++;
                total_cnt++; if (host_bus.rvalid !== !prev_c) $display("FAIL streak_host_rvalid[%0d]: got %b expected %b", i, host_bus.rvalid, !prev_c); else pass_cnt++;
            end
            prev_c = exp_c;
            @(negedge clk);
        end
        cpu_bus.req = 1'b0; host_bus.req = 1'b0;
        total_cnt++; if (host_bus.rdata !== 4'h7) $display("FAIL streak_host_rdata: got %h expected 7", host_bus.rdata); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_clear();
        int w; logic g;
        int busy_n = 0; int done_n = 0; int leak_n = 0;
        logic done_gnt = 1'b0; logic rv_after = 1'b0; logic [3:0] rd_after = 4'hx;
        cpu_access(1'b1, 8'h1F, 4'h9, w, g);
        host_access(1'b1, 8'hFF, 4'h5, w, g);
        host_access(1'b0, 8'h1F, 4'h0, w, g);
        total_cnt++; if (host_bus.rdata !== 4'h9) $display("FAIL clr_preload: got %h expected 9", host_bus.rdata); else pass_cnt++;
        clr_start = 1'b1;
        host_bus.req = 1'b1; host_bus.we = 1'b0; host_bus.addr = 8'h1F;
        #1;
        total_cnt++; if (host_bus.gnt !== 1'b0) $display("FAIL clr_start_no_gnt: got %b expected 0", host_bus.gnt); else pass_cnt++;
        for (int j = 0; j < 262; j++) begin
            @(negedge clk);
            clr_start = 1'b0;
            if (done_n == 1 && host_bus.req) begin
                host_bus.req = 1'b0;
                rv_after = host_bus.rvalid;
                rd_after = host_bus.rdata;
            end
            #1;
            if (clr_busy) begin
                busy_n++;
                if (cpu_bus.gnt || host_bus.gnt) leak_n++;
            end
            if (clr_done) begin
                done_n++;
                done_gnt = host_bus.gnt;
            end
        end
        host_bus.req = 1'b0;
        total_cnt++; if (busy_n != 256) $display("FAIL clr_busy_cycles: got %0d expected 256", busy_n); else pass_cnt++;
        total_cnt++; if (done_n != 1) $display("FAIL clr_done_pulses: got %0d expected 1", done_n); else pass_cnt++;
        total_cnt++; if (leak_n != 0) $display("FAIL clr_grant_leak: got %0d expected 0", leak_n); else pass_cnt++;
        total_cnt++; if (done_gnt !== 1'b1) $display("FAIL clr_pending_host_gnt: got %b expected 1", done_gnt); else pass_cnt++;
        total_cnt++; if (!(rv_after === 1'b1 && rd_after === 4'h0)) $display("FAIL clr_read_1f: rvalid %b rdata %h expected 1 and 0", rv_after, rd_after); else pass_cnt++;
        @(negedge clk);
        cpu_access(1'b0, 8'hFF, 4'h0, w, g);
        total_cnt++; if (!(cpu_bus.rvalid === 1'b1 && cpu_bus.rdata === 4'h0)) $display("FAIL clr_read_ff: rvalid %b rdata %h expected 1 and 0", cpu_bus.rvalid, cpu_bus.rdata); else pass_cnt++;
    endtask

    task automatic test_clear_pending();
        int k = 0; int early = 0;
        clr_start = 1'b1;
        #1;
        while (k < 300) begin
            @(negedge clk);
            clr_start = 1'b0;
            if (k == 10) begin
                cpu_bus.req = 1'b1; cpu_bus.we = 1'b0; cpu_bus.addr = 8'h05;
            end
            #1;
            if (!clr_busy) break;
            if (cpu_bus.gnt) early++;
            k++;
        end
        total_cnt++; if (k != 256) $display("FAIL pend_first_arb_cycle: got %0d expected 256", k); else pass_cnt++;
        total_cnt++; if (early != 0) $display("FAIL pend_early_gnt: got %0d expected 0", early); else pass_cnt++;
        total_cnt++; if (cpu_bus.gnt !== 1'b1) $display("FAIL pend_cpu_gnt: got %b expected 1", cpu_bus.gnt); else pass_cnt++;
        total_cnt++; if (clr_done !== 1'b1) $display("FAIL pend_with_done: got %b expected 1", clr_done); else pass_cnt++;
        @(negedge clk);
        cpu_bus.req = 1'b0;
        total_cnt++; if (!(cpu_bus.rvalid === 1'b1 && cpu_bus.rdata === 4'h0)) $display("FAIL pend_read: rvalid %b rdata %h expected 1 and 0", cpu_bus.rvalid, cpu_bus.rdata); else pass_cnt++;
    endtask

    task automatic test_reset_mid_clear();
        int w; logic g; int done_n = 0;
        cpu_access(1'b1, 8'h00, 4'h3, w, g);
        cpu_access(1'b1, 8'h63, 4'h4, w, g);
        cpu_access(1'b1, 8'h80, 4'hA, w, g);
        clr_start = 1'b1;
        for (int k = 0; k <= 100; k++) begin
            @(negedge clk);
            clr_start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        total_cnt++; if (clr_busy !== 1'b0) $display("FAIL rstclr_busy: got %b expected 0", clr_busy); else pass_cnt++;
        for (int k = 0; k < 300; k++) begin
            if (clr_done) done_n++;
            @(negedge clk); #1;
        end
        total_cnt++; if (done_n != 0) $display("FAIL rstclr_done_pulses: got %0d expected 0", done_n); else pass_cnt++;
        @(negedge clk);
        cpu_access(1'b0, 8'h00, 4'h0, w, g);
        total_cnt++; if (!(w == 0 && cpu_bus.rdata === 4'h0)) $display("FAIL rstclr_addr00: waits %0d rdata %h expected 0 and 0", w, cpu_bus.rdata); else pass_cnt++;
        cpu_access(1'b0, 8'h63, 4'h0, w, g);
        total_cnt++; if (cpu_bus.rdata !== 4'h0) $display("FAIL rstclr_addr63: got %h expected 0", cpu_bus.rdata); else pass_cnt++;
        cpu_access(1'b0, 8'h80, 4'h0, w, g);
        total_cnt++; if (cpu_bus.rdata !== 4'hA) $display("FAIL rstclr_addr80: got %h expected a", cpu_bus.rdata); else pass_cnt++;
    endtask

    task automatic test_host_only();
        int k = 0;
        host_bus.req = 1'b1; host_bus.we = 1'b0; host_bus.addr = 8'h80;
        for (int i = 0; i < 6; i++) begin
            #1;
            total_cnt++; if (!(host_bus.gnt === 1'b1 && cpu_bus.gnt === 1'b0)) $display("FAIL hostonly_gnt[%0d]: host %b cpu %b expected 1 and 0", i, host_bus.gnt, cpu_bus.gnt); else pass_cnt++;
            @(negedge clk);
        end
        total_cnt++; if (host_bus.rdata !== 4'hA) $display("FAIL hostonly_rdata: got %h expected a", host_bus.rdata); else pass_cnt++;
        cpu_bus.req = 1'b1; cpu_bus.we = 1'b0; cpu_bus.addr = 8'h80;
        for (int i = 0; i < 5; i++) begin
            #1;
            total_cnt++; if (cpu_bus.gnt !== (i != 4)) $display("FAIL hostonly_streak0[%0d]: cpu_gnt %b expected %b", i, cpu_bus.gnt, i != 4); else pass_cnt++;
            @(negedge clk);
        end
        cpu_bus.req = 1'b0;
        clr_start = 1'b1;
        #1;
        total_cnt++; if (host_bus.gnt !== 1'b0) $display("FAIL hostonly_clr_no_gnt: got %b expected 0", host_bus.gnt); else pass_cnt++;
        @(negedge clk);
        clr_start = 1'b0;
        #1;
        total_cnt++; if (clr_busy !== 1'b1) $display("FAIL hostonly_clr_entered: got %b expected 1", clr_busy); else pass_cnt++;
        while (clr_busy && k < 300) begin
            @(negedge clk); #1; k++;
        end
        total_cnt++; if (!(clr_busy === 1'b0 && host_bus.gnt === 1'b1)) $display("FAIL hostonly_after_clr: busy %b host_gnt %b expected 0 and 1", clr_busy, host_bus.gnt); else pass_cnt++;
        @(negedge clk);
        host_bus.req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int w; logic g;
        cpu_access(1'b1, 8'h40, 4'hC, w, g);
        cpu_access(1'b0, 8'h40, 4'h0, w, g);
        total_cnt++; if (!(w == 0 && cpu_bus.rvalid === 1'b1 && cpu_bus.rdata === 4'hC)) $display("FAIL b2b_cpu_raw: waits %0d rvalid %b rdata %h expected 0 1 c", w, cpu_bus.rvalid, cpu_bus.rdata); else pass_cnt++;
        host_access(1'b0, 8'h40, 4'h0, w, g);
        total_cnt++; if (host_bus.rdata !== 4'hC) $display("FAIL b2b_host_read: got %h expected c", host_bus.rdata); else pass_cnt++;
        host_access(1'b1, 8'h41, 4'h5, w, g);
        total_cnt++; if (host_bus.rdata !== 4'hC) $display("FAIL b2b_host_rdata_hold: got %h expected c", host_bus.rdata); else pass_cnt++;
        cpu_access(1'b0, 8'h41, 4'h0, w, g);
        total_cnt++; if (!(w == 0 && cpu_bus.rdata === 4'h5)) $display("FAIL b2b_cross_raw: waits %0d rdata %h expected 0 and 5", w, cpu_bus.rdata); else pass_cnt++;
    endtask

    initial begin
        cpu_bus.req = 1'b0; cpu_bus.we = 1'b0; cpu_bus.addr = '0; cpu_bus.wdata = '0;
        host_bus.req = 1'b0; host_bus.we = 1'b0; host_bus.addr = '0; host_bus.wdata = '0;
        test_reset();
        test_write_read();
        test_priority_streak();
        test_clear();
        test_clear_pending();
        test_reset_mid_clear();
        test_host_only();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
